// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer loading path.
package vga_pkg;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         DEF_IMG_W          = 640;
    localparam int         DEF_IMG_H          = 480;
    localparam logic [7:0] DEF_SYNC_BYTE      = 8'hA5;
    localparam int         DEF_TIMEOUT_CYCLES = 1000000;

    // Width needed to address 'size' entries; never narrower than one bit.
    function automatic int calc_addr_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/framebuffer_ram.sv
// Simple dual-port framebuffer: one write port fed by the loader and a
// registered read port for the pixel path.
module framebuffer_ram
    import vga_pkg::*;
#(
    parameter int DEPTH  = DEF_IMG_W * DEF_IMG_H,
    parameter int ADDR_W = calc_addr_w(DEPTH),
    parameter int DATA_W = 4
) (
    input  logic              clk_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one pixel per strobe.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered so it maps onto block RAM output registers.
    always_ff @(posedge clk_in) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_loader.sv
// Byte-stream to framebuffer loader. A sync byte opens a frame, then each
// payload byte carries two 4-bit pixels (high nibble first) that are written
// in raster order. A stall longer than the timeout aborts the frame.
module frame_loader
    import vga_pkg::*;
#(
    parameter int         IMG_W          = DEF_IMG_W,
    parameter int         IMG_H          = DEF_IMG_H,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int         ADDR_W         = calc_addr_w(IMG_W * IMG_H)
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              error
);

    localparam int                IMG_SIZE = IMG_W * IMG_H;
    localparam int                TO_W     = calc_addr_w(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(IMG_SIZE - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [3:0]        low_nib_reg, low_nib_next;
    logic [TO_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic              wr_en_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [3:0]        wr_data_next;
    logic              frame_done_next;
    logic              error_next;
    logic              accept;

    // LO is spent writing the latched low nibble and DONE only issues the
    // completion pulse, so neither takes a byte.
    assign in_ready = (state_reg == IDLE) || (state_reg == HI);
    assign busy     = (state_reg == HI) || (state_reg == LO);
    assign accept   = in_valid && in_ready;

    // Next-state, pixel pointer, stall counter and write-port decode.
    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        low_nib_next    = low_nib_reg;
        idle_cnt_next   = '0;
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr;
        wr_data_next    = wr_data;
        frame_done_next = 1'b0;
        error_next      = error;

        case (state_reg)
            IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_next = HI;
                    ptr_next   = '0;
                    error_next = 1'b0;
                end
            end
            HI: begin
                if (accept) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = ptr_reg;
                    wr_data_next = in_data[7:4];
                    low_nib_next = in_data[3:0];
                    if (ptr_reg == LAST_PTR) begin
                        // Odd pixel count: the low nibble has no pixel to land in.
                        state_next = DONE;
                    end else begin
                        state_next = LO;
                        ptr_next   = ptr_reg + 1'b1;
                    end
                end else if (idle_cnt_reg == TO_LAST) begin
                    // Stream stalled too long: abandon the partial frame.
                    state_next = IDLE;
                    error_next = 1'b1;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            LO: begin
                wr_en_next   = 1'b1;
                wr_addr_next = ptr_reg;
                wr_data_next = low_nib_reg;
                if (ptr_reg == LAST_PTR) begin
                    state_next = DONE;
                end else begin
                    state_next = HI;
                    ptr_next   = ptr_reg + 1'b1;
                end
            end
            DONE: begin
                frame_done_next = 1'b1;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any frame in progress.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            low_nib_reg  <= '0;
            idle_cnt_reg <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_done   <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            low_nib_reg  <= low_nib_next;
            idle_cnt_reg <= idle_cnt_next;
            wr_en        <= wr_en_next;
            wr_addr      <= wr_addr_next;
            wr_data      <= wr_data_next;
            frame_done   <= frame_done_next;
            error        <= error_next;
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: an even-sized (4x2) and an odd-sized
// (3x1) loader, with a framebuffer RAM behind the even one.
module tb_frame_loader;

    typedef struct {
        bit         is_done;
        int         addr;
        logic [3:0] data;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       resetn;
    logic       iv0, iv1;
    logic [7:0] id0, id1;
    logic       rdy0, wen0, busy0, fd0, err0;
    logic [2:0] wa0;
    logic [3:0] wd0;
    logic       rdy1, wen1, busy1, fd1, err1;
    logic [1:0] wa1;
    logic [3:0] wd1;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    int         wcyc0[$];
    bit         prev_we[2];
    bit         m_load[2];
    int         m_idx[2];
    int         m_size[2] = '{8, 3};
    logic [3:0] img0[8];

    always #5 clk_in = ~clk_in;

    frame_loader #(.IMG_W(4), .IMG_H(2), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(8)) u_even (
        .clk_in(clk_in), .resetn(resetn), .in_valid(iv0), .in_data(id0),
        .in_ready(rdy0), .wr_en(wen0), .wr_addr(wa0), .wr_data(wd0),
        .busy(busy0), .frame_done(fd0), .error(err0)
    );

    frame_loader #(.IMG_W(3), .IMG_H(1), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(8)) u_odd (
        .clk_in(clk_in), .resetn(resetn), .in_valid(iv1), .in_data(id1),
        .in_ready(rdy1), .wr_en(wen1), .wr_addr(wa1), .wr_data(wd1),
        .busy(busy1), .frame_done(fd1), .error(err1)
    );

    framebuffer_ram #(.DEPTH(8), .ADDR_W(3), .DATA_W(4)) u_fb (
        .clk_in(clk_in), .wr_en(wen0), .wr_addr(wa0), .wr_data(wd0),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic bit pop_exp(input int k, output exp_t e);
        e = '{is_done: 1'b0, addr: 0, data: 4'h0};
        if (k == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    // Reference model: a frame is a run of pixels addressed 0..size-1.
    task automatic push_pix(input int k, input logic [3:0] nib);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = m_idx[k];
        e.data    = nib;
        if (k == 0) begin
            q0.push_back(e);
            img0[m_idx[k]] = nib;
        end else begin
            q1.push_back(e);
        end
        m_idx[k]++;
        if (m_idx[k] == m_size[k]) begin
            e.is_done = 1'b1;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
            m_load[k] = 1'b0;
        end
    endtask

    task automatic model_accept(input int k, input logic [7:0] b);
        if (!m_load[k]) begin
            if (b == 8'hA5) begin
                m_load[k] = 1'b1;
                m_idx[k]  = 0;
            end
        end else begin
            push_pix(k, b[7:4]);
            if (m_load[k]) push_pix(k, b[3:0]);
        end
    endtask

    task automatic set_in(input int k, input logic v, input logic [7:0] d);
        if (k == 0) begin iv0 = v; id0 = d; end
        else        begin iv1 = v; id1 = d; end
    endtask

    function automatic logic get_rdy(input int k);
        return (k == 0) ? rdy0 : rdy1;
    endfunction

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input int k, input logic [7:0] b);
        int n = 0;
        set_in(k, 1'b1, b);
        while (!get_rdy(k) && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        if (!get_rdy(k)) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake[%0d]: got in_ready=0 for %0d cycles, required 1", k, n);
            set_in(k, 1'b0, 8'h00);
            return;
        end
        model_accept(k, b);
        @(negedge clk_in);
        set_in(k, 1'b0, 8'h00);
    endtask

    task automatic idle(input int k, input int g);
        set_in(k, 1'b0, 8'h00);
        repeat (g) @(negedge clk_in);
    endtask

    task automatic check_ram();
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            @(negedge clk_in);
            chk($sformatf("ram[%0d]", a), {28'b0, rd_data}, {28'b0, img0[a]});
        end
    endtask

    task automatic check_reset_outputs(input int k);
        if (k == 0) begin
            chk("rst0_wr_en", {31'b0, wen0}, 32'd0);
            chk("rst0_wr_addr", {29'b0, wa0}, 32'd0);
            chk("rst0_wr_data", {28'b0, wd0}, 32'd0);
            chk("rst0_frame_done", {31'b0, fd0}, 32'd0);
            chk("rst0_error", {31'b0, err0}, 32'd0);
            chk("rst0_in_ready", {31'b0, rdy0}, 32'd1);
            chk("rst0_busy", {31'b0, busy0}, 32'd0);
        end else begin
            chk("rst1_wr_en", {31'b0, wen1}, 32'd0);
            chk("rst1_wr_addr", {30'b0, wa1}, 32'd0);
            chk("rst1_wr_data", {28'b0, wd1}, 32'd0);
            chk("rst1_frame_done", {31'b0, fd1}, 32'd0);
            chk("rst1_error", {31'b0, err1}, 32'd0);
            chk("rst1_in_ready", {31'b0, rdy1}, 32'd1);
            chk("rst1_busy", {31'b0, busy1}, 32'd0);
        end
    endtask

    // Monitor: every write or frame_done the DUT shows must match the queue head.
    task automatic mon(input int k, input logic we, input logic [31:0] addr,
                       input logic [3:0] d, input logic fd);
        exp_t e;
        bit   ok;
        if (we) begin
            if (k == 0) wcyc0.push_back(cyc);
            ok = pop_exp(k, e);
            vectors++;
            if (!ok || e.is_done) begin
                miscompares++;
                $display("FAIL wr_unexpected[%0d]: got write addr=%0d data=%0h, required none", k, addr, d);
            end else if (addr !== 32'(e.addr) || d !== e.data) begin
                miscompares++;
                $display("FAIL wr_pixel[%0d]: got addr=%0d data=%0h, required addr=%0d data=%0h",
                         k, addr, d, e.addr, e.data);
            end
        end
        if (fd) begin
            ok = pop_exp(k, e);
            vectors++;
            if (!ok || !e.is_done || we || !prev_we[k]) begin
                miscompares++;
                $display("FAIL frame_done[%0d]: got pulse (expected_done=%0d prev_wr=%0d), required pulse right after final write",
                         k, ok && e.is_done, prev_we[k]);
            end
        end
        prev_we[k] = we;
    endtask

    always @(negedge clk_in) begin
        cyc++;
        if (resetn === 1'b1) begin
            mon(0, wen0, {29'b0, wa0}, wd0, fd0);
            mon(1, wen1, {30'b0, wa1}, wd1, fd1);
        end
    end

    initial begin
        logic [7:0] b;
        int         k;
        resetn  = 1'b0;
        iv0     = 1'b0; iv1 = 1'b0;
        id0     = 8'h00; id1 = 8'h00;
        rd_addr = 3'd0;
        #12;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(negedge clk_in);
        resetn = 1'b1;
        @(negedge clk_in);

        // Directed 4x2 frame, bytes back to back: eight writes on consecutive cycles.
        wcyc0.delete();
        send_byte(0, 8'hA5);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        send_byte(0, 8'h56);
        send_byte(0, 8'h78);
        idle(0, 4);
        chk("t1_write_count", 32'(wcyc0.size()), 32'd8);
        if (wcyc0.size() == 8) chk("t1_write_span", 32'(wcyc0[7] - wcyc0[0]), 32'd7);
        chk("t1_busy_after", {31'b0, busy0}, 32'd0);
        chk("t1_queue_drained", 32'(q0.size()), 32'd0);

        // Junk ahead of the sync byte is dropped; then a normal frame.
        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        send_byte(0, 8'h5A);
        send_byte(0, 8'hA5);
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom));
        idle(0, 4);
        check_ram();

        // Odd 3x1 frame: the final low nibble is discarded.
        send_byte(1, 8'hA5);
        send_byte(1, 8'h9A);
        send_byte(1, 8'hBC);
        idle(1, 4);
        chk("t3_queue_drained", 32'(q1.size()), 32'd0);
        chk("t3_busy_after", {31'b0, busy1}, 32'd0);

        // Stall in HI: error lands after exactly eight idle cycles.
        send_byte(0, 8'hA5);
        send_byte(0, 8'h12);
        repeat (8) @(negedge clk_in);
        chk("t4_error_before", {31'b0, err0}, 32'd0);
        chk("t4_busy_before", {31'b0, busy0}, 32'd1);
        @(negedge clk_in);
        chk("t4_error_set", {31'b0, err0}, 32'd1);
        chk("t4_busy_cleared", {31'b0, busy0}, 32'd0);
        m_load[0] = 1'b0;
        idle(0, 3);
        chk("t4_error_sticky", {31'b0, err0}, 32'd1);
        send_byte(0, 8'hA5);
        chk("t4_error_cleared", {31'b0, err0}, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom));
        idle(0, 4);
        chk("t4_queue_drained", 32'(q0.size()), 32'd0);

        // Asynchronous reset in the middle of a frame.
        send_byte(0, 8'hA5);
        send_byte(0, 8'($urandom));
        send_byte(0, 8'($urandom));
        idle(0, 2);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs(0);
        m_load[0] = 1'b0;
        m_load[1] = 1'b0;
        chk("t5_queue_empty", 32'(q0.size()), 32'd0);
        @(negedge clk_in);
        resetn = 1'b1;
        @(negedge clk_in);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        idle(0, 4);
        chk("t5_no_frame_busy", {31'b0, busy0}, 32'd0);

        // Random frames with short gaps and leading junk on both loaders.
        for (int f = 0; f < 20; f++) begin
            k = f % 2;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                idle(k, int'($urandom_range(0, 5)));
                send_byte(k, b);
            end
            idle(k, int'($urandom_range(0, 5)));
            send_byte(k, 8'hA5);
            for (int j = 0; j < (m_size[k] + 1) / 2; j++) begin
                idle(k, int'($urandom_range(0, 5)));
                send_byte(k, 8'($urandom));
            end
            idle(k, 4);
            chk($sformatf("rnd%0d_error", f), {31'b0, (k == 0) ? err0 : err1}, 32'd0);
            if (k == 0) check_ram();
        end

        idle(0, 5);
        chk("final_q0_drained", 32'(q0.size()), 32'd0);
        chk("final_q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Streaming loader that fills the writable framebuffer RAM read by the VGA pixel path; upstream of the framebuffer, downstream of the UART receiver.
- Accepts a byte stream over a valid/ready handshake.
- Each frame is a SYNC_BYTE header followed by packed 4-bit grayscale pixels, two per byte, high nibble first.
- Emits one RAM write per pixel in raster order, then a one-cycle frame_done pulse; a stalled stream aborts with a sticky error.

Parameters:
IMG_W, 640, image width in pixels
IMG_H, 480, image height in pixels
SYNC_BYTE, 8'hA5, frame-start marker byte
TIMEOUT_CYCLES, 1000000, max idle cycles between payload bytes before abort (>=1)
(derived) IMG_SIZE = IMG_W*IMG_H (must be >=2); ADDR_W = $clog2(IMG_SIZE), min 1

Ports:
clk_in  input  1  pixel-domain clock
resetn  input  1  async active-low reset
in_valid  input  1  byte available
in_data  input  8  byte value
in_ready  output  1  loader can accept byte
wr_en  output  1  framebuffer write strobe
wr_addr  output  ADDR_W  framebuffer write address (v*IMG_W+h)
wr_data  output  4  pixel value
busy  output  1  frame load in progress (state HI or LO)
frame_done  output  1  one-cycle pulse, full frame written
error  output  1  sticky timeout flag, cleared by next SYNC_BYTE

Behaviour:
- Clock/reset: one clock, clk_in; reset is asynchronous, active-low, port resetn.
- Reset values: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, frame_done=0, error=0; in_ready=1 (combinational from state); busy=0.
- Outputs wr_en, wr_addr, wr_data, frame_done, error are registered. in_ready and busy are combinational decodes of state.
- Accept: a byte transfers on a rising edge where in_valid & in_ready. in_data is sampled only on accept.
- States:
  - IDLE: in_ready=1. An accepted byte == SYNC_BYTE -> HI, pixel address ptr=0, error<=0. Any other byte is dropped, stay IDLE.
  - HI: in_ready=1, timeout counter running. On accept:
    - Next cycle: wr_en=1, wr_addr=ptr, wr_data=in_data[7:4]; low nibble latched.
    - If ptr==IMG_SIZE-1: go DONE; the latched low nibble is discarded (odd IMG_SIZE).
    - Else: go LO, ptr<=ptr+1.
    - A SYNC_BYTE value in HI is treated as pixel data, not resync.
  - LO: in_ready=0. Next cycle: wr_en=1, wr_addr=ptr, wr_data=latched low nibble.
    - If ptr==IMG_SIZE-1: go DONE; else go HI, ptr<=ptr+1.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Latency: accept at edge N gives the high-nibble write visible in cycle N+1 and the low-nibble write in cycle N+2. in_ready returns high in cycle N+2. Sustained rate is one byte per 2 cycles.
- wr_en is 0 in every cycle without a scheduled write. wr_addr/wr_data hold their last values when wr_en=0.
- Timeout: in HI, a counter increments each cycle without an accept and clears on accept. On reaching TIMEOUT_CYCLES-1: error<=1, go IDLE, no frame_done, partial frame stays in RAM. The counter does not run in IDLE, LO or DONE.
- ptr wraps never: the DONE transition occurs exactly at IMG_SIZE-1.
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh SYNC_BYTE.

Decomposition:
- Shared package vga_pkg:
  - state typedef enum {IDLE, HI, LO, DONE}
  - default IMG_W/IMG_H constants
  - SYNC_BYTE constant
  - helper function for ADDR_W.
- One natural sub-module: framebuffer_ram, a simple dual-port RAM with a write port from this block and a registered read port for the pixel path. It is instantiated at top level, not inside frame_loader.

Test Plan:
- IMG_W=4, IMG_H=2, bytes A5,12,34,56,78, in_valid constant -> writes (0,1),(1,2),(2,3),(3,4),(4,5),(5,6),(6,7),(7,8) on consecutive cycles; in_ready alternates 1/0; frame_done one cycle after addr7 write; busy low after.
- Junk bytes 00,FF,5A before A5 -> no wr_en; load then proceeds normally from addr0.
- IMG_W=3, IMG_H=1, bytes A5,9A,BC -> writes (0,9),(1,A),(2,B); nibble C discarded; frame_done pulses once.
- TIMEOUT_CYCLES=8: A5,12 then in_valid=0 -> error=1 after 8 idle cycles in HI, state IDLE, no frame_done; next A5 clears error.
- Assert resetn=0 after 2 payload bytes -> all outputs 0, in_ready=1 asynchronously; payload without A5 produces no writes.
- Random in_valid gaps shorter than the timeout -> written image matches the packed source byte-for-byte; wr_en never asserted in consecutive cycles beyond 2.
